// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared stall/flush bus encodings, exception codes and FSM states
package stall_ctrl_pkg;
   typedef logic [5:0] stall_bus_t;
   typedef logic [4:0] exc_code_t;
   localparam logic STOP    = 1'b1;
   localparam logic NOSTOP  = 1'b0;
   localparam logic FLUSH   = 1'b1;
   localparam logic NOFLUSH = 1'b0;
   localparam exc_code_t EXC_NONE = 5'h10;
   localparam exc_code_t EXC_ERET = 5'h11;
   localparam int ST_PC  = 0;
   localparam int ST_IF  = 1;
   localparam int ST_ID  = 2;
   localparam int ST_EXE = 3;
   localparam int ST_MEM = 4;
   localparam int ST_WB  = 5;
   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_IF   = 6'b000011;
   localparam stall_bus_t STALL_ID   = 6'b000111;
   localparam stall_bus_t STALL_EXE  = 6'b001111;
   localparam stall_bus_t STALL_MEM  = 6'b011111;
   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;
endpackage

// File: rtl/stall_ctrl.sv
// stall_ctrl: merges stage stall requests, turns MEM exceptions into a flush, drains a stale fetch
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_exe,
   input  logic        stallreq_mem,
   input  logic [4:0]  mem_exccode,
   input  logic [31:0] cp0_epc,
   input  logic        if_busy,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        if_discard,
   output logic [31:0] stall_cycles
);
   state_e      state_q, state_d;
   logic [31:0] stall_cycles_q;
   logic        exc_take;
   // An exception stuck behind a data-SRAM wait is held until the access finishes
   assign exc_take     = (mem_exccode != EXC_NONE) && !stallreq_mem;
   assign stall_cycles = stall_cycles_q;
   // Next state and outputs: DRAIN ignores the pipeline, flush beats every stall request
   always_comb begin
      state_d    = state_q;
      stall      = STALL_NONE;
      flush      = NOFLUSH;
      flush_pc   = '0;
      if_discard = 1'b0;
      if (state_q == DRAIN) begin
         stall      = STALL_IF;
         if_discard = 1'b1;
         state_d    = if_busy ? DRAIN : RUN;
      end else if (exc_take) begin
         flush    = FLUSH;
         flush_pc = (mem_exccode == EXC_ERET) ? cp0_epc : EXC_ENTRY;
         state_d  = if_busy ? DRAIN : RUN;
      end else begin
         stall = stallreq_mem ? STALL_MEM :
                 stallreq_exe ? STALL_EXE :
                 stallreq_id  ? STALL_ID  :
                 stallreq_if  ? STALL_IF  : STALL_NONE;
      end
   end
   // State register and wrapping count of PC-stalled cycles
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q        <= RUN;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_q + 32'(stall[ST_PC]);
      end
   end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench for stall_ctrl priority, flush, drain, reset and counter wrap
module tb_stall_ctrl;
   import stall_ctrl_pkg::*;
   typedef struct packed {
      logic        rst, rif, rid, rexe, rmem;
      logic [4:0]  exc;
      logic [31:0] epc;
      logic        busy;
      logic [5:0]  st;
      logic        fl;
      logic [31:0] pc;
      logic        disc;
   } vec_t;
   typedef logic [39:0] exp_t;
   localparam logic [4:0]  N   = EXC_NONE;
   localparam logic [4:0]  OV  = 5'h0C;
   localparam logic [31:0] ENT = 32'hBFC0_0380;
   logic        clk = 1'b0;
   logic        cpu_rst, stallreq_if, stallreq_id, stallreq_exe, stallreq_mem, if_busy;
   logic [4:0]  mem_exccode;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush, if_discard;
   logic [31:0] flush_pc, stall_cycles;
   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] cnt_model = '0;
   logic        cnt_ok = 1'b0;

   stall_ctrl #(.EXC_ENTRY(32'hBFC0_0380)) dut (
      .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_exe(stallreq_exe), .stallreq_mem(stallreq_mem), .mem_exccode(mem_exccode),
      .cp0_epc(cp0_epc), .if_busy(if_busy), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .if_discard(if_discard), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, rif, rid, rexe, rmem, input logic [4:0] exc,
                               input logic [31:0] epc, input logic busy, input logic [5:0] st,
                               input logic fl, input logic [31:0] pc, input logic disc);
      mk = '{rst, rif, rid, rexe, rmem, exc, epc, busy, st, fl, pc, disc};
   endfunction

   task automatic drive(input vec_t v);
      @(posedge clk);
      #1;
      cpu_rst      = v.rst;
      stallreq_if  = v.rif;
      stallreq_id  = v.rid;
      stallreq_exe = v.rexe;
      stallreq_mem = v.rmem;
      mem_exccode  = v.exc;
      cp0_epc      = v.epc;
      if_busy      = v.busy;
      exp_q.push_back({v.st, v.fl, v.pc, v.disc});
   endtask

   task automatic test_reset;
      vec_t tv[3];
      exp_t e;
      tv[0] = mk(1, 1, 1, 0, 0, N, 0, 0, 6'b000111, 0, 0, 0);
      tv[1] = mk(1, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      tv[2] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL reset[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         if (cnt_ok) begin
            n_vec++;
            if (stall_cycles !== cnt_model) begin
               n_bad++;
               $display("FAIL reset[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
            end
         end
         if (tv[i].rst) begin cnt_model = '0; cnt_ok = 1'b1; end
         else if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_priority;
      vec_t tv[7];
      exp_t e;
      tv[0] = mk(0, 1, 1, 0, 0, N, 0, 0, 6'b000111, 0, 0, 0);
      tv[1] = mk(0, 1, 1, 0, 0, N, 0, 0, 6'b000111, 0, 0, 0);
      tv[2] = mk(0, 1, 1, 0, 0, N, 0, 1, 6'b000111, 0, 0, 0);
      tv[3] = mk(0, 1, 0, 0, 0, N, 0, 0, 6'b000011, 0, 0, 0);
      tv[4] = mk(0, 1, 1, 1, 0, N, 0, 0, 6'b001111, 0, 0, 0);
      tv[5] = mk(0, 1, 1, 1, 1, N, 0, 0, 6'b011111, 0, 0, 0);
      tv[6] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL priority[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL priority[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_exc_mem_stall;
      vec_t tv[6];
      exp_t e;
      tv[0] = mk(0, 0, 0, 0, 1, OV, 0, 0, 6'b011111, 0, 0, 0);
      tv[1] = mk(0, 0, 0, 0, 1, OV, 0, 0, 6'b011111, 0, 0, 0);
      tv[2] = mk(0, 0, 0, 0, 1, OV, 0, 0, 6'b011111, 0, 0, 0);
      tv[3] = mk(0, 0, 0, 0, 0, OV, 32'h1111_2222, 0, 6'b000000, 1, ENT, 0);
      tv[4] = mk(0, 1, 1, 1, 0, OV, 0, 0, 6'b000000, 1, ENT, 0);
      tv[5] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL exc_mem[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL exc_mem[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_eret;
      vec_t tv[3];
      exp_t e;
      tv[0] = mk(0, 0, 1, 0, 0, EXC_ERET, 32'h8000_1234, 0, 6'b000000, 1, 32'h8000_1234, 0);
      tv[1] = mk(0, 0, 0, 0, 0, N, 32'h8000_1234, 0, 6'b000000, 0, 0, 0);
      tv[2] = mk(0, 0, 1, 0, 0, N, 32'h8000_1234, 1, 6'b000111, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL eret[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL eret[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_drain;
      vec_t tv[6];
      exp_t e;
      tv[0] = mk(0, 0, 0, 0, 0, OV, 0, 1, 6'b000000, 1, ENT, 0);
      tv[1] = mk(0, 1, 1, 1, 1, OV, 0, 1, 6'b000011, 0, 0, 1);
      tv[2] = mk(0, 0, 0, 0, 0, EXC_ERET, 32'h1234, 0, 6'b000011, 0, 0, 1);
      tv[3] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      tv[4] = mk(0, 0, 0, 0, 0, EXC_ERET, 32'h8000_0040, 1, 6'b000000, 1, 32'h8000_0040, 0);
      tv[5] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000011, 0, 0, 1);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL drain[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL drain[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_reset_drain;
      vec_t tv[5];
      exp_t e;
      tv[0] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      tv[1] = mk(0, 0, 0, 0, 0, OV, 0, 1, 6'b000000, 1, ENT, 0);
      tv[2] = mk(0, 0, 0, 0, 0, N, 0, 1, 6'b000011, 0, 0, 1);
      tv[3] = mk(1, 0, 0, 0, 0, N, 0, 1, 6'b000011, 0, 0, 1);
      tv[4] = mk(0, 0, 0, 0, 0, N, 0, 1, 6'b000000, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL reset_drain[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL reset_drain[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].rst) cnt_model = '0;
         else if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   task automatic test_wrap;
      vec_t tv[3];
      exp_t e;
      #1;
      force dut.stall_cycles_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cycles_q;
      cnt_model = 32'hFFFF_FFFE;
      tv[0] = mk(0, 1, 0, 0, 0, N, 0, 0, 6'b000011, 0, 0, 0);
      tv[1] = mk(0, 0, 0, 1, 0, N, 0, 0, 6'b001111, 0, 0, 0);
      tv[2] = mk(0, 0, 0, 0, 0, N, 0, 0, 6'b000000, 0, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i]);
         #3;
         e = exp_q.pop_front();
         n_vec++;
         if ({stall, flush, flush_pc, if_discard} !== e) begin
            n_bad++;
            $display("FAIL wrap[%0d] outputs got %h want %h", i, {stall, flush, flush_pc, if_discard}, e);
         end
         n_vec++;
         if (stall_cycles !== cnt_model) begin
            n_bad++;
            $display("FAIL wrap[%0d] stall_cycles got %h want %h", i, stall_cycles, cnt_model);
         end
         if (tv[i].st[0]) cnt_model = cnt_model + 1;
      end
   endtask

   initial begin
      cpu_rst      = 1'b1;
      stallreq_if  = 1'b0;
      stallreq_id  = 1'b0;
      stallreq_exe = 1'b0;
      stallreq_mem = 1'b0;
      mem_exccode  = N;
      cp0_epc      = '0;
      if_busy      = 1'b0;
      test_reset;
      test_priority;
      test_exc_mem_stall;
      test_eret;
      test_drain;
      test_reset_drain;
      test_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
